// File: rtl/rotl_pipe.sv
// Pipelined log rotator: result STAGES cycles after accept, whole pipe stalls while out_valid && !out_ready.
// Define ROTL_BIDIR_EN to add in_dir (1 = rotate right); the default build rotates left only.
module rotl_pipe #(
  parameter  int WIDTH  = 32,
  localparam int STAGES = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [STAGES-1:0] in_amt,
`ifdef ROTL_BIDIR_EN
  input  logic              in_dir,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [STAGES:0]   occupancy
);

  logic              advance;
  logic              accept;
  logic              consume;
  logic [STAGES-1:0] amt_in;
  logic [STAGES:0]   occ_q, occ_d;

  function automatic logic [WIDTH-1:0] rotl_c(input logic [WIDTH-1:0] d, input int sh);
    return (d << sh) | (d >> (WIDTH - sh));
  endfunction

`ifdef ROTL_BIDIR_EN
  // WIDTH is a power of two, so negating the amount gives (WIDTH - amt) mod WIDTH.
  assign amt_in = in_dir ? ('0 - in_amt) : in_amt;
`else
  assign amt_in = in_amt;
`endif

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign consume  = out_valid && out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int B = STAGES - 1 - k;
    logic [WIDTH-1:0] src_dat, dat_d, dat_q;
    logic [B:0]       src_amt;
    logic             src_vld, vld_q;

    if (k == 0) begin : g_src
      assign src_dat = in_data;
      assign src_amt = amt_in;
      assign src_vld = in_valid;
    end else begin : g_src
      assign src_dat = g_stg[k-1].dat_q;
      assign src_amt = g_stg[k-1].g_amt.amt_q;
      assign src_vld = g_stg[k-1].vld_q;
    end

    assign dat_d = src_amt[B] ? rotl_c(src_dat, 1 << B) : src_dat;

    // Bubbles move forward as invalid stages but never overwrite data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (advance) begin
        vld_q <= src_vld;
        if (src_vld) dat_q <= dat_d;
      end
    end

    // Only the amount bits still to be applied travel onward.
    if (B > 0) begin : g_amt
      logic [B-1:0] amt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q <= '0;
        end else if (advance && src_vld) begin
          amt_q <= src_amt[B-1:0];
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].vld_q;
  assign out_data  = g_stg[STAGES-1].dat_q;

  always_comb begin
    occ_d = occ_q;
    if (accept && !consume) begin
      occ_d = occ_q + {{STAGES{1'b0}}, 1'b1};
    end else if (consume && !accept) begin
      occ_d = occ_q - {{STAGES{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule
